// File: rtl/keyram_pkg.sv
// keyram_pkg: shared constants and types for the HDCP key-RAM port arbiter.
// Holds the RAM geometry defaults, the requester id encoding and the
// in-flight read tag carried through the read-latency pipeline.
package keyram_pkg;

  localparam int KEYRAM_WIDTH  = 64;
  localparam int KEYRAM_ADDR_W = 6;
  localparam int KEYRAM_LAT_HP = 2;  // RAM with output register
  localparam int KEYRAM_LAT_LL = 1;  // RAM without output register

  // Requester identity: loader is the host register path, cipher is the
  // HDCP cipher key fetch.
  typedef enum logic {
    KR_ID_LOADER = 1'b0,
    KR_ID_CIPHER = 1'b1
  } kr_id_e;

  // One in-flight read slot.
  typedef struct packed {
    logic   valid;
    kr_id_e id;
  } kr_tag_t;

endpackage

// File: rtl/keyram_rd_track.sv
// keyram_rd_track: follows each granted read through the RAM read latency
// and steers the returned word to the requester that issued it. Only
// READ_LATENCY of 1 or 2 is accepted.
module keyram_rd_track
  import keyram_pkg::*;
#(
  parameter int RAM_WIDTH    = KEYRAM_WIDTH,
  parameter int READ_LATENCY = KEYRAM_LAT_HP
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  kr_tag_t              tag_in,
  input  logic [RAM_WIDTH-1:0] ram_dout,
  output logic                 ram_regce,
  output logic                 m0_rvalid,
  output logic [RAM_WIDTH-1:0] m0_rdata,
  output logic                 m1_rvalid,
  output logic [RAM_WIDTH-1:0] m1_rdata
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("keyram_rd_track: READ_LATENCY must be 1 or 2");
  end

  kr_tag_t [READ_LATENCY:1] stage_r;
  kr_tag_t                  ret_s;
  logic [RAM_WIDTH-1:0]     m0_hold_r;
  logic [RAM_WIDTH-1:0]     m1_hold_r;

  // Shift the in-flight tags one stage per cycle; reset drops all of them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_r <= '0;
    end else begin
      stage_r[1] <= tag_in;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // The output register only needs to capture when a read is in stage 1.
  if (READ_LATENCY == 2) begin : g_regce
    assign ram_regce = stage_r[1].valid;
  end else begin : g_no_regce
    assign ram_regce = 1'b0;
  end

  // Demultiplex the returning word to its owner; the other side keeps its data.
  always_comb begin
    ret_s     = stage_r[READ_LATENCY];
    m0_rvalid = ret_s.valid && (ret_s.id == KR_ID_LOADER);
    m1_rvalid = ret_s.valid && (ret_s.id == KR_ID_CIPHER);
    if (m0_rvalid) begin
      m0_rdata = ram_dout;
    end else begin
      m0_rdata = m0_hold_r;
    end
    if (m1_rvalid) begin
      m1_rdata = ram_dout;
    end else begin
      m1_rdata = m1_hold_r;
    end
  end

  // Remember the last word returned to each requester so rdata stays stable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m0_hold_r <= '0;
      m1_hold_r <= '0;
    end else begin
      if (m0_rvalid) begin
        m0_hold_r <= ram_dout;
      end
      if (m1_rvalid) begin
        m1_hold_r <= ram_dout;
      end
    end
  end

endmodule

// File: rtl/keyram_port_arb.sv
// keyram_port_arb: round-robin arbiter between the key loader (m0) and the
// cipher key fetch (m1) for one port of the HDCP key RAM. One access is
// granted per cycle; read returns are routed back by keyram_rd_track.
// Optional build macro KEYRAM_ARB_WLOCK_EN adds a wlock input that turns
// granted writes into no-ops and flags them on wr_err.
module keyram_port_arb
  import keyram_pkg::*;
#(
  parameter int RAM_WIDTH    = KEYRAM_WIDTH,
  parameter int ADDR_WIDTH   = KEYRAM_ADDR_W,
  parameter int READ_LATENCY = KEYRAM_LAT_HP
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [RAM_WIDTH-1:0]  m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [RAM_WIDTH-1:0]  m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [RAM_WIDTH-1:0]  m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [RAM_WIDTH-1:0]  m1_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]  ram_din,
  output logic                  ram_regce,
`ifdef KEYRAM_ARB_WLOCK_EN
  input  logic                  wlock,
  output logic                  wr_err,
`endif
  input  logic [RAM_WIDTH-1:0]  ram_dout
);

  kr_id_e                last_gnt_r;
  kr_id_e                win_s;
  logic                  any_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [RAM_WIDTH-1:0]  sel_wdata_s;
  logic [ADDR_WIDTH-1:0] addr_hold_r;
  logic [RAM_WIDTH-1:0]  din_hold_r;
  logic                  wlock_s;
  kr_tag_t               tag_s;

`ifdef KEYRAM_ARB_WLOCK_EN
  assign wlock_s = wlock;
`else
  assign wlock_s = 1'b0;
`endif

  // Pick the winner: a lone requester wins, contention goes to the side
  // that was not granted last. Nothing is granted while reset is asserted.
  always_comb begin
    any_s = 1'b0;
    win_s = KR_ID_LOADER;
    if (!rstn) begin
      any_s = 1'b0;
    end else if (m0_req && m1_req) begin
      any_s = 1'b1;
      win_s = (last_gnt_r == KR_ID_LOADER) ? KR_ID_CIPHER : KR_ID_LOADER;
    end else if (m0_req) begin
      any_s = 1'b1;
      win_s = KR_ID_LOADER;
    end else if (m1_req) begin
      any_s = 1'b1;
      win_s = KR_ID_CIPHER;
    end else begin
      any_s = 1'b0;
    end
  end

  // Route the winner's command onto the RAM port; idle cycles keep the
  // previous address and data on the bus.
  always_comb begin
    if (win_s == KR_ID_CIPHER) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
    m0_gnt = any_s && (win_s == KR_ID_LOADER);
    m1_gnt = any_s && (win_s == KR_ID_CIPHER);
    ram_en = any_s;
    ram_we = any_s && sel_we_s && !wlock_s;
    if (any_s) begin
      ram_addr = sel_addr_s;
      ram_din  = sel_wdata_s;
    end else begin
      ram_addr = addr_hold_r;
      ram_din  = din_hold_r;
    end
    tag_s.valid = any_s && !sel_we_s;
    tag_s.id    = win_s;
  end

  // Round-robin pointer and bus hold registers update on every grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt_r  <= KR_ID_CIPHER;
      addr_hold_r <= '0;
      din_hold_r  <= '0;
    end else if (any_s) begin
      last_gnt_r  <= win_s;
      addr_hold_r <= sel_addr_s;
      din_hold_r  <= sel_wdata_s;
    end
  end

`ifdef KEYRAM_ARB_WLOCK_EN
  // Flag each write that was granted but suppressed by the lock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= any_s && sel_we_s && wlock_s;
    end
  end
`endif

  keyram_rd_track #(
    .RAM_WIDTH    (RAM_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_track (
    .clk       (clk),
    .rstn      (rstn),
    .tag_in    (tag_s),
    .ram_dout  (ram_dout),
    .ram_regce (ram_regce),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata)
  );

endmodule

// File: tb/tb_keyram_port_arb.sv
// tb_keyram_port_arb: directed bench for keyram_port_arb. Instance dut uses
// READ_LATENCY=2, instance dut1 uses READ_LATENCY=1; each sits on a small
// read-first RAM model. The lock scenario runs when KEYRAM_ARB_WLOCK_EN is set.
module tb_keyram_port_arb;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  // latency-2 instance
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [5:0]  m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [63:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we, ram_regce;
  logic [5:0]  ram_addr;
  logic [63:0] ram_din, ram_dout;
  logic [63:0] mem0 [0:63];
  logic [63:0] q1_0, q2_0;

  // latency-1 instance
  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [5:0]  b_m0_addr, b_m1_addr;
  logic [63:0] b_m0_wdata, b_m1_wdata;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
  logic [63:0] b_m0_rdata, b_m1_rdata;
  logic        b_ram_en, b_ram_we, b_ram_regce;
  logic [5:0]  b_ram_addr;
  logic [63:0] b_ram_din, b_ram_dout;
  logic [63:0] mem1 [0:63];
  logic [63:0] q1_1;

`ifdef KEYRAM_ARB_WLOCK_EN
  logic wlock, wr_err, b_wlock, b_wr_err;
`endif

  keyram_port_arb #(.RAM_WIDTH(64), .ADDR_WIDTH(6), .READ_LATENCY(2)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_regce(ram_regce),
`ifdef KEYRAM_ARB_WLOCK_EN
    .wlock(wlock), .wr_err(wr_err),
`endif
    .ram_dout(ram_dout)
  );

  keyram_port_arb #(.RAM_WIDTH(64), .ADDR_WIDTH(6), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din),
    .ram_regce(b_ram_regce),
`ifdef KEYRAM_ARB_WLOCK_EN
    .wlock(b_wlock), .wr_err(b_wr_err),
`endif
    .ram_dout(b_ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first RAM with optional output register (latency 2).
  always @(posedge clk) begin
    if (ram_en) begin
      q1_0 <= mem0[ram_addr];
      if (ram_we) mem0[ram_addr] <= ram_din;
    end
    if (ram_regce) q2_0 <= q1_0;
  end
  assign ram_dout = q2_0;

  // Read-first RAM without output register (latency 1).
  always @(posedge clk) begin
    if (b_ram_en) begin
      q1_1 <= mem1[b_ram_addr];
      if (b_ram_we) mem1[b_ram_addr] <= b_ram_din;
    end
  end
  assign b_ram_dout = q1_1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge, where inputs are driven
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  localparam logic [63:0] D_A5  = 64'hA5A5_0000_1111_2222;
  localparam logic [63:0] D_63  = 64'hDEAD_BEEF_6363_0042;
  localparam logic [63:0] D_M1  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D_M2  = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D_B7  = 64'h7777_0000_7777_0007;
  localparam logic [63:0] D_OLD = 64'h0000_0000_0000_0333;

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 64'd0;
      mem1[i] = 64'd0;
    end
    mem0[1] = D_M1;
    mem0[2] = D_M2;
    mem0[3] = D_OLD;
    mem1[7] = D_B7;
    q1_0 = 64'd0; q2_0 = 64'd0; q1_1 = 64'd0;
    rstn = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 6'd0; m0_wdata = 64'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 6'd0; m1_wdata = 64'd0;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = 6'd0; b_m0_wdata = 64'd0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = 6'd0; b_m1_wdata = 64'd0;
`ifdef KEYRAM_ARB_WLOCK_EN
    wlock = 1'b0;
    b_wlock = 1'b0;
`endif

    // reset state
    repeat (2) tick();
    at_sample();
    check_val("rst_ram_en", {63'd0, ram_en}, 64'd0);
    check_val("rst_gnt", {62'd0, m0_gnt, m1_gnt}, 64'd0);
    check_val("rst_rvalid", {62'd0, m0_rvalid, m1_rvalid}, 64'd0);
    check_val("rst_addr", {58'd0, ram_addr}, 64'd0);
    tick();
    rstn = 1'b1;

    // contention: both read continuously, grants alternate starting with m0
    tick();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd2;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      at_sample();
      if (c < 4) begin
        check_val("cont_m0_gnt", {63'd0, m0_gnt}, (c % 2 == 0) ? 64'd1 : 64'd0);
        check_val("cont_m1_gnt", {63'd0, m1_gnt}, (c % 2 == 1) ? 64'd1 : 64'd0);
        check_val("cont_addr", {58'd0, ram_addr}, (c % 2 == 0) ? 64'd1 : 64'd2);
      end else begin
        check_val("cont_idle_en", {63'd0, ram_en}, 64'd0);
      end
      if (c >= 2) begin
        check_val("cont_m0_rvalid", {63'd0, m0_rvalid}, (c % 2 == 0) ? 64'd1 : 64'd0);
        check_val("cont_m1_rvalid", {63'd0, m1_rvalid}, (c % 2 == 1) ? 64'd1 : 64'd0);
        if (c % 2 == 0) check_val("cont_m0_rdata", m0_rdata, D_M1);
        else            check_val("cont_m1_rdata", m1_rdata, D_M2);
      end
      tick();
    end

    // m0 writes addr 5, m1 reads it back two cycles after its grant
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd5; m0_wdata = D_A5;
    at_sample();
    check_val("wr5_gnt", {63'd0, m0_gnt}, 64'd1);
    check_val("wr5_we", {63'd0, ram_we}, 64'd1);
    check_val("wr5_din", ram_din, D_A5);
    tick();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd5;
    at_sample();
    check_val("rd5_gnt", {63'd0, m1_gnt}, 64'd1);
    check_val("rd5_we", {63'd0, ram_we}, 64'd0);
    tick();
    m1_req = 1'b0;
    at_sample();
    check_val("rd5_early", {63'd0, m1_rvalid}, 64'd0);
    check_val("rd5_regce", {63'd0, ram_regce}, 64'd1);
    check_val("idle_addr_hold", {58'd0, ram_addr}, 64'd5);
    tick();
    at_sample();
    check_val("rd5_rvalid", {63'd0, m1_rvalid}, 64'd1);
    check_val("rd5_rdata", m1_rdata, D_A5);
    check_val("rd5_m0_rvalid", {63'd0, m0_rvalid}, 64'd0);
    tick();
    at_sample();
    check_val("rd5_pulse", {63'd0, m1_rvalid}, 64'd0);
    check_val("rd5_hold", m1_rdata, D_A5);
    tick();

    // m1 writes addr 63, m0 reads it on the very next cycle
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd63; m1_wdata = D_63;
    at_sample();
    check_val("wr63_gnt", {63'd0, m1_gnt}, 64'd1);
    tick();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd63;
    at_sample();
    check_val("rd63_gnt", {63'd0, m0_gnt}, 64'd1);
    check_val("rd63_addr", {58'd0, ram_addr}, 64'd63);
    tick();
    m0_req = 1'b0;
    at_sample();
    check_val("wr63_no_rvalid", {63'd0, m1_rvalid}, 64'd0);
    tick();
    at_sample();
    check_val("rd63_rvalid", {63'd0, m0_rvalid}, 64'd1);
    check_val("rd63_rdata", m0_rdata, D_63);
    tick();

    // reset while a read is in flight
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd5;
    at_sample();
    check_val("rstmid_gnt", {63'd0, m0_gnt}, 64'd1);
    tick();
    rstn = 1'b0;
    at_sample();
    check_val("rstmid_gnt0", {63'd0, m0_gnt}, 64'd0);
    check_val("rstmid_en0", {63'd0, ram_en}, 64'd0);
    check_val("rstmid_rvalid0", {63'd0, m0_rvalid}, 64'd0);
    check_val("rstmid_rdata0", m0_rdata, 64'd0);
    check_val("rstmid_regce0", {63'd0, ram_regce}, 64'd0);
    tick();
    rstn = 1'b1;
    m0_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      at_sample();
      check_val("rstmid_no_rvalid", {63'd0, m0_rvalid}, 64'd0);
      tick();
    end

    // latency-1 instance: single m0 read
    b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 6'd7;
    at_sample();
    check_val("l1_gnt", {63'd0, b_m0_gnt}, 64'd1);
    check_val("l1_regce_a", {63'd0, b_ram_regce}, 64'd0);
    tick();
    b_m0_req = 1'b0;
    at_sample();
    check_val("l1_rvalid", {63'd0, b_m0_rvalid}, 64'd1);
    check_val("l1_rdata", b_m0_rdata, D_B7);
    check_val("l1_regce_b", {63'd0, b_ram_regce}, 64'd0);
    tick();
    at_sample();
    check_val("l1_pulse", {63'd0, b_m0_rvalid}, 64'd0);
    tick();

`ifdef KEYRAM_ARB_WLOCK_EN
    // locked write is granted but suppressed and flagged
    wlock = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd3; m0_wdata = 64'hFF;
    at_sample();
    check_val("wl_gnt", {63'd0, m0_gnt}, 64'd1);
    check_val("wl_we", {63'd0, ram_we}, 64'd0);
    check_val("wl_err_pre", {63'd0, wr_err}, 64'd0);
    tick();
    m0_req = 1'b0;
    wlock = 1'b0;
    at_sample();
    check_val("wl_err", {63'd0, wr_err}, 64'd1);
    tick();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd3;
    at_sample();
    check_val("wl_err_end", {63'd0, wr_err}, 64'd0);
    check_val("wl_no_rvalid", {63'd0, m0_rvalid}, 64'd0);
    check_val("wl_rd_gnt", {63'd0, m0_gnt}, 64'd1);
    tick();
    m0_req = 1'b0;
    tick();
    at_sample();
    check_val("wl_rd_rvalid", {63'd0, m0_rvalid}, 64'd1);
    check_val("wl_rd_rdata", m0_rdata, D_OLD);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keyram_port_arb.md
Name: keyram_port_arb

Overview:
- Two-requester arbiter/sequencer in front of one port of the HDCP key-storage dual-port RAM.
- Requester 0 is the key loader (host register path); requester 1 is the HDCP cipher key fetch.
- Grants one access per cycle and drives the RAM port enable, write and output-register controls.
- Tracks in-flight reads through the RAM read latency and routes returned data back to the issuing requester.

Parameters:
- RAM_WIDTH, 64, data width of the RAM port.
- ADDR_WIDTH, 6, address width (64-entry RAM).
- READ_LATENCY, 2, RAM read latency in cycles. Legal values are 1 (no output register) and 2 (output register); any other value is an elaboration error.

Ports:
- clk  in  1  single clock, shared with the RAM port.
- rstn  in  1  asynchronous active-low reset.
- m0_req  in  1  requester 0 access request; held until granted.
- m0_we  in  1  requester 0 write (1) or read (0).
- m0_addr  in  ADDR_WIDTH  requester 0 address.
- m0_wdata  in  RAM_WIDTH  requester 0 write data.
- m0_gnt  out  1  one-cycle pulse when the m0 request is accepted.
- m0_rvalid  out  1  m0 read data valid.
- m0_rdata  out  RAM_WIDTH  m0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0 signals, for requester 1.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM port write enable.
- ram_addr  out  ADDR_WIDTH  RAM port address.
- ram_din  out  RAM_WIDTH  RAM port write data.
- ram_regce  out  1  RAM output register enable (used only when READ_LATENCY=2).
- ram_dout  in  RAM_WIDTH  RAM port read data.

Behaviour:
- Reset (async assert, sync deassert by the system): all outputs 0, round-robin pointer last_gnt=1, in-flight pipeline cleared.
- Arbitration (combinational from registered last_gnt):
  - Exactly one of m0/m1 requesting: that requester wins.
  - Both requesting: the requester that is not last_gnt wins.
  - last_gnt updates on every grant. After reset, m0 wins the first contention.
- Grant cycle:
  - ram_en=1 and gnt pulse are asserted in the same cycle.
  - ram_we, ram_addr and ram_din are muxed combinationally from the winner.
  - The requester samples gnt and may present a new request in the next cycle. Back-to-back grants to the same requester are legal if the other requester is idle.
- Idle cycle: ram_en=0, ram_we=0; ram_addr and ram_din hold their last values.
- Read tracking:
  - A READ_LATENCY-deep shift register of {valid, id} is loaded on each read grant; write grants load valid=0.
  - When stage READ_LATENCY is valid, it drives mX_rvalid=1 (registered-equivalent timing, exactly READ_LATENCY cycles after gnt) and mX_rdata=ram_dout for the matching id. The non-matching requester sees rvalid=0.
  - rdata is held otherwise.
- ram_regce: equals stage-1 valid when READ_LATENCY=2; constant 0 when READ_LATENCY=1.
- Throughput: one access per cycle, sustained. Reads and writes may be interleaved with no bubbles.
- Write-then-read to the same address on consecutive cycles returns the new data; the RAM is read-first on the same cycle only.
- Write grants produce no rvalid. The old-data return from the read-first RAM is discarded.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after reset. Requesters must re-issue.
- A request deasserted before gnt is withdrawn with no side effects.

Optional Feature:
- Macro: KEYRAM_ARB_WLOCK_EN.
- When defined, adds input wlock (1 bit) and output wr_err (1 bit). While wlock=1, write grants still pulse gnt but force ram_we=0, and wr_err pulses for 1 cycle. Reads are unaffected. wr_err resets to 0.
- When not defined, neither port exists and writes are never suppressed.

Decomposition:
- Shared package keyram_pkg holds:
  - Constants KEYRAM_WIDTH=64, KEYRAM_ADDR_W=6, KEYRAM_LAT_HP=2, KEYRAM_LAT_LL=1.
  - Requester id typedef (1 bit: KR_ID_LOADER=0, KR_ID_CIPHER=1).
  - In-flight tag struct {valid, id}.
- One natural sub-module: keyram_rd_track, the parameterised latency shift register plus return demux. The arbiter logic stays in the top module.

Test Plan:
- Reset, then m0 writes addr 5 = 64'hA5A5_0000_1111_2222, then m1 reads addr 5 -> m1_gnt next cycle; m1_rvalid exactly 2 cycles after m1_gnt with m1_rdata=64'hA5A5_0000_1111_2222; m0_rvalid stays 0.
- Both request reads continuously, addrs 1 and 2 -> grants alternate m0,m1,m0,..., m0 first; one grant per cycle; rvalid ids alternate with 2-cycle lag.
- Set READ_LATENCY=1, single m0 read -> rvalid 1 cycle after gnt; ram_regce constant 0.
- m0 read granted, then rstn pulsed low before return -> no m0_rvalid after reset; all outputs 0 during reset.
- m1 write to addr 63, then an immediate m0 read of addr 63 on the next cycle -> m0_rdata equals the new write data. Address wraps cleanly with no out-of-range access.
- KEYRAM_ARB_WLOCK_EN defined, wlock=1, m0 writes 64'hFF to addr 3 -> m0_gnt=1, ram_we=0, wr_err pulses 1 cycle; a subsequent read of addr 3 returns its prior value.
